// File: rtl/mul_div_if.sv
// Handshake bundle between the core's operand/result stage and the multi-cycle divider.
// The core drives requests through the master modport; the divider answers through the slave modport.
interface mul_div_if #(
  parameter int N = 31
);
  logic         start;
  logic [1:0]   op;
  logic [N:0]   a;
  logic [N:0]   b;
  logic         busy;
  logic         done;
  logic [N:0]   result;

  modport master (
    output start, op, a, b,
    input  busy, done, result
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result
  );
endinterface

// File: rtl/mul_div_unit.sv
// RV32M divide unit (DIV/DIVU/REM/REMU): radix-2 restoring divider, one quotient bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and complete in a single cycle.
module mul_div_unit #(
  parameter int N = 31
) (
  input  logic       clk,
  input  logic       rst,
  mul_div_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int CW = $clog2(N + 2);

  state_t          state;
  logic [1:0]      op_q;
  logic            qneg;
  logic            rneg;
  logic [N:0]      divisor;
  logic [N:0]      rem;
  logic [N:0]      quot;
  logic [CW-1:0]   count;

  logic            is_signed;
  logic [N:0]      a_abs;
  logic [N:0]      b_abs;
  logic            b_zero;
  logic            ovf;
  logic [N:0]      res_special;
  logic [N+1:0]    rem_sh;
  logic [N+1:0]    trial;
  logic [N:0]      rem_nxt;
  logic [N:0]      quot_nxt;
  logic [N:0]      res_calc;

  // NOTE: every signal gets a value on every path through this block, so no latches are inferred.
  always_comb begin
    is_signed   = ~bus.op[0];
    a_abs       = (is_signed && bus.a[N]) ? -bus.a : bus.a;
    b_abs       = (is_signed && bus.b[N]) ? -bus.b : bus.b;
    b_zero      = (bus.b == '0);
    ovf         = is_signed && (bus.a == {1'b1, {N{1'b0}}}) && (bus.b == '1);
    res_special = bus.op[1] ? (b_zero ? bus.a : '0) : (b_zero ? '1 : bus.a);

    // The shifted partial remainder can exceed N+1 bits for unsigned divisors, hence the extra bit.
    rem_sh   = {rem, quot[N]};
    trial    = rem_sh - {1'b0, divisor};
    rem_nxt  = trial[N+1] ? rem_sh[N:0] : trial[N:0];
    quot_nxt = {quot[N-1:0], ~trial[N+1]};

    if (op_q[1]) begin
      res_calc = (rneg && !op_q[0]) ? -rem_nxt : rem_nxt;
    end else begin
      res_calc = (qneg && !op_q[0]) ? -quot_nxt : quot_nxt;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= '0;
      qneg       <= 1'b0;
      rneg       <= 1'b0;
      divisor    <= '0;
      rem        <= '0;
      quot       <= '0;
      count      <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q     <= bus.op;
            qneg     <= is_signed & (bus.a[N] ^ bus.b[N]);
            rneg     <= is_signed & bus.a[N];
            divisor  <= b_abs;
            rem      <= '0;
            quot     <= a_abs;
            count    <= CW'(N + 1);
            bus.busy <= 1'b1;
            if (b_zero || ovf) begin
              bus.result <= res_special;
              bus.done   <= 1'b1;
              state      <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end

        CALC: begin
          rem   <= rem_nxt;
          quot  <= quot_nxt;
          count <= count - 1'b1;
          // Last iteration: sign-corrected result is captured on the same edge.
          if (count == CW'(1)) begin
            bus.result <= res_calc;
            bus.done   <= 1'b1;
            state      <= DONE;
          end
        end

        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected results queued at issue, checked on each done pulse.
// Also checks latency, busy length, result hold, ignored starts, async abort and back-to-back starts.
module tb_mul_div_unit;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef struct {
    logic [31:0] res;
    int          lat;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_div_if #(.N(31)) bus ();
  mul_div_unit #(.N(31)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          busy_cnt = 0;
  int          prev_done = -1;
  bit          prev_busy = 1'b0;
  bit          held = 1'b0;
  logic [31:0] last_result = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
    case (op)
      OP_DIV:  return $signed(a) / $signed(b);
      OP_REM:  return $signed(a) % $signed(b);
      OP_DIVU: return a / b;
      default: return a % b;
    endcase
  endfunction

  always @(posedge clk) cyc++;

  // Output monitor: everything sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt  = 0;
      prev_busy = 1'b0;
    end else begin
      if (bus.busy && !prev_busy) begin
        acc_cyc  = cyc;
        busy_cnt = 0;
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check({e.tag, "_res"}, bus.result, e.res);
          check({e.tag, "_lat"}, 32'(cyc - acc_cyc), 32'(e.lat));
          check({e.tag, "_busy"}, 32'(busy_cnt), 32'(e.lat + 1));
          if (held) begin
            if (prev_done >= 0) check("held_period", 32'(cyc - prev_done), 32'd34);
            prev_done = cyc;
          end
        end
        last_result = bus.result;
      end else begin
        check("result_hold", bus.result, last_result);
      end
      prev_busy = bus.busy;
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !bus.busy) return;
      @(negedge clk);
    end
    check("idle_timeout", 32'd1, 32'd0);
    sb.delete();
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string tag);
    exp_t e;
    wait_idle();
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    e.res = exp;
    e.lat = is_special(op, a, b) ? 0 : 32;
    e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    #12;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors with hand-derived results.
    issue(OP_DIVU, 32'd100, 32'd7, 32'd14, "divu_100_7");
    issue(OP_REMU, 32'd100, 32'd7, 32'd2, "remu_100_7");
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2");
    issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2");
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, "divu_big");
    issue(OP_DIV, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, "div_by0");
    issue(OP_REMU, 32'h1234_5678, 32'd0, 32'h1234_5678, "remu_by0");
    issue(OP_REM, 32'h8765_4321, 32'd0, 32'h8765_4321, "rem_by0_neg");
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_ovf");
    issue(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "divu_nonovf");
    issue(OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "remu_nonovf");
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7_m2");
    issue(OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, "rem_7_m2");

    // Random mix, with small or zero divisors mixed in.
    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom();
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom();
      issue(rop, ra, rb, ref_div(rop, ra, rb), "rand");
    end

    // A start pulse while busy must not be latched.
    issue(OP_DIVU, 32'd100, 32'd7, 32'd14, "mid_ignore");
    repeat (8) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_DIVU;
    bus.a     = 32'd1;
    bus.b     = 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    // Asynchronous abort mid-calculation: outputs clear at once and no done follows.
    issue(OP_DIVU, 32'd100, 32'd7, 32'd14, "abort");
    repeat (13) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_result", bus.result, 32'd0);
    sb.delete();
    last_result = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(OP_DIVU, 32'd100, 32'd7, 32'd14, "after_abort");
    wait_idle();

    // start held high: a new operation is accepted on the first edge back in IDLE.
    held = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_DIVU;
    bus.a     = 32'd9;
    bus.b     = 32'd3;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.res = 32'd3;
      e.lat = 32;
      e.tag = "held";
      sb.push_back(e);
    end
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    bus.start = 1'b0;
    if (sb.size() != 0) begin
      check("held_timeout", 32'd1, 32'd0);
      sb.delete();
    end
    check("held_count", 32'(prev_done >= 0), 32'd1);
    wait_idle();
    held = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle RV32M divide unit for femtoRV32. Executes DIV, DIVU, REM and REMU.
- Sits between ID/EX operand selection and the result register. Its result feeds that register's D input, and its done pulse drives the register's load.
- Uses a radix-2 restoring algorithm at one quotient bit per cycle. The core stalls on busy.

Parameters:
- N, 31, MSB index of operands and result. Datapath width is N+1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU; latched with start.
- a  input  N+1  dividend; latched with start.
- b  input  N+1  divisor; latched with start.
- busy  output  1  high from the cycle after start is accepted through the DONE cycle inclusive.
- done  output  1  one-cycle pulse; result is valid in this cycle.
- result  output  N+1  quotient or remainder; held until the next accepted start.

Behaviour:
- Reset, asynchronous: state=IDLE, busy=0, done=0, result=0, all internal registers=0. It takes effect immediately, including mid-operation. An aborted operation produces no done pulse.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 on edge k latches op, a and b.
  - Signed ops (DIV, REM) store |a| and |b|, plus sign flags: qneg = a[N]^b[N], rneg = a[N].
  - Special cases go directly to DONE at edge k, so done is high in cycle k+1:
    - b==0: DIV/DIVU result = all ones; REM/REMU result = a.
    - Signed op with a==100..0 and b==all ones: DIV result = a; REM result = 0.
  - Otherwise go to CALC with count=N+1, remainder=0, quotient=|a|.
- CALC: one iteration per edge.
  - Shift {rem, quot} left by 1.
  - trial = rem - divisor, at N+2 bits.
  - If trial >= 0: rem = trial and quot LSB = 1. Otherwise quot LSB = 0.
  - Decrement count. When count reaches 0, go to DONE and load result in the same edge.
  - Result select and sign fix: quotient for DIV/DIVU, negated if qneg and signed; remainder for REM/REMU, negated if rneg and signed.
- DONE: done=1, busy=1 for exactly one cycle, then IDLE.
- Latency, normal path: start accepted at edge k. CALC spans edges k+1..k+N+1 (32 edges at N=31). done is high in cycle k+N+2 (k+33 at N=31).
- Latency, special-case path: done is high in cycle k+1.
- start while busy, including in the DONE cycle: ignored, with no latching. start may be re-asserted in the cycle after done.
- Back-to-back: start held high is accepted again on the first edge in IDLE.
- Rounding: quotient truncates toward zero; remainder takes the sign of the dividend (RISC-V semantics). Negation is two's complement at N+1 bits.
- result changes only on the edge entering DONE, or on reset. It is stable at all other times, including during CALC of a later operation.
- No combinational path from any input to any output. All outputs are registered.

Test Plan:
- DIVU a=100, b=7, start in one cycle: busy=1 for 33 cycles, done pulse 33 cycles after the start edge, result=14. Repeat with REMU: result=2.
- DIV a=-7 (0xFFFFFFF9), b=2: result=0xFFFFFFFD (-3). REM with the same operands: result=0xFFFFFFFF (-1). DIVU a=0xFFFFFFFF, b=0x10: result=0x0FFFFFFF.
- Divide by zero, a=0x12345678, b=0: DIV gives 0xFFFFFFFF, REMU gives 0x12345678. done is high in the cycle after start; busy is high for exactly one cycle.
- Overflow, DIV a=0x80000000, b=0xFFFFFFFF: result=0x80000000 in 1 cycle. REM with the same operands: result=0.
- Mid-operation: start DIVU 100/7, pulse start with a=1, b=1 at cycle 10 (must be ignored; the result is still 14). Then a new operation is asserted rst at cycle 15: busy=0, done=0, result=0 immediately, no done pulse follows. The next start completes normally.
- start held high continuously with DIVU 9/3: done pulses every 34 cycles, result=3 each time, and result stays stable between pulses.
